// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and constants for the pipeline hazard controller.
//   slot_t      : in-flight instruction record {v, addr, we, ld} for EXE/MEM/WB
//   FWD_*       : operand bypass source encodings driven on fwd_sel_rs/fwd_sel_rt
//   slot_match  : RAW compare of one slot against one ID source operand
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam int HZ_SLOT_WD = 8;

  typedef struct packed {
    logic       v;
    logic [4:0] addr;
    logic       we;
    logic       ld;
  } slot_t;

  // $0 is hard-wired zero, so a write to it can never create a dependency.
  function automatic logic slot_match(input slot_t s, input logic [4:0] r, input logic used);
    return s.v & s.we & (s.addr == r) & (r != 5'd0) & used;
  endfunction

endpackage

// File: rtl/hazard_ctrl_slot.sv
// hazard_ctrl_slot: one tracked pipeline stage (EXE, MEM or WB).
//   clk, reset          : clock, synchronous active-high reset (clears v)
//   fill, fill_data     : load the slot with the upstream record this edge
//   drain               : upstream left without refilling; invalidate this edge
//   rs_addr/rt_addr/... : ID source operands to compare against
//   q                   : current slot contents
//   rs_match, rt_match  : RAW match per operand
module hazard_ctrl_slot
  import hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       fill,
  input  logic       drain,
  input  slot_t      fill_data,
  input  logic [4:0] rs_addr,
  input  logic [4:0] rt_addr,
  input  logic       rs_used,
  input  logic       rt_used,
  output slot_t      q,
  output logic       rs_match,
  output logic       rt_match
);

  slot_t slot_reg;

  // Fill has priority over drain: a stage that hands off and receives a new
  // instruction on the same edge stays occupied.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_reg <= '0;
    end else if (fill) begin
      slot_reg <= fill_data;
    end else if (drain) begin
      slot_reg.v <= 1'b0;
    end
  end

  assign q        = slot_reg;
  assign rs_match = slot_match(slot_reg, rs_addr, rs_used);
  assign rt_match = slot_match(slot_reg, rt_addr, rt_used);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: interlock / forwarding scheduler for the 5-stage pipeline.
// Mirrors the ID->EXE->MEM->WB handshakes to know which destination registers
// are in flight, then decides whether ID must hold and where each source
// operand should be bypassed from.
//   clk, reset                       : clock, synchronous active-high reset
//   id_valid, id_rs/rt_addr, *_used  : ID instruction and its source operands
//   id_dest_addr, id_dest_we, id_is_load : ID instruction destination info
//   id_fire, exe_fire, mem_fire, wb_retire : stage transfer strobes
//   id_ready_go                      : 0 holds ID this cycle
//   fwd_sel_rs, fwd_sel_rt           : bypass source (RF/EXE/MEM/WB)
//   stall_cnt                        : count of cycles ID was held with a valid inst
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter bit FORWARD_EN = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [4:0]       id_dest_addr,
  input  logic             id_dest_we,
  input  logic             id_is_load,
  input  logic             id_fire,
  input  logic             exe_fire,
  input  logic             mem_fire,
  input  logic             wb_retire,
  output logic             id_ready_go,
  output logic [1:0]       fwd_sel_rs,
  output logic [1:0]       fwd_sel_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  // Index 0 = EXE, 1 = MEM, 2 = WB.
  slot_t       slot_q    [3];
  slot_t       slot_fill_data [3];
  logic  [2:0] slot_fill;
  logic  [2:0] slot_drain;
  logic  [2:0] rs_match;
  logic  [2:0] rt_match;
  logic        stall;
  logic [CNT_W-1:0] stall_cnt_reg;

  // An id_fire during a stall is a protocol error upstream; it is dropped so
  // the tracking never records an instruction that should not have advanced.
  assign slot_fill[0]      = id_fire & id_ready_go;
  assign slot_fill[1]      = exe_fire;
  assign slot_fill[2]      = mem_fire;
  assign slot_drain[0]     = exe_fire;
  assign slot_drain[1]     = mem_fire;
  assign slot_drain[2]     = wb_retire;
  assign slot_fill_data[0] = '{v: 1'b1, addr: id_dest_addr, we: id_dest_we, ld: id_is_load};
  assign slot_fill_data[1] = slot_q[0];
  assign slot_fill_data[2] = slot_q[1];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
      hazard_ctrl_slot u_slot (
        .clk       (clk),
        .reset     (reset),
        .fill      (slot_fill[gi]),
        .drain     (slot_drain[gi]),
        .fill_data (slot_fill_data[gi]),
        .rs_addr   (id_rs_addr),
        .rt_addr   (id_rt_addr),
        .rs_used   (id_rs_used),
        .rt_used   (id_rt_used),
        .q         (slot_q[gi]),
        .rs_match  (rs_match[gi]),
        .rt_match  (rt_match[gi])
      );
    end
  endgenerate

  always_comb begin
    stall      = 1'b0;
    fwd_sel_rs = FWD_RF;
    fwd_sel_rt = FWD_RF;
    if (FORWARD_EN) begin
      // Only a load sitting in EXE has no result yet; everything else bypasses.
      stall = slot_q[0].ld & (rs_match[0] | rt_match[0]);
      // Youngest producer wins.
      if (rs_match[0])      fwd_sel_rs = FWD_EXE;
      else if (rs_match[1]) fwd_sel_rs = FWD_MEM;
      else if (rs_match[2]) fwd_sel_rs = FWD_WB;
      if (rt_match[0])      fwd_sel_rt = FWD_EXE;
      else if (rt_match[1]) fwd_sel_rt = FWD_MEM;
      else if (rt_match[2]) fwd_sel_rt = FWD_WB;
    end else begin
      // Without bypass the RF is written at the WB edge, so a WB match must
      // still wait one cycle before the read sees the new value.
      stall = (|rs_match) | (|rt_match);
    end
    if (!id_valid) begin
      stall      = 1'b0;
      fwd_sel_rs = FWD_RF;
      fwd_sel_rt = FWD_RF;
    end
  end

  assign id_ready_go = ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (id_valid && !id_ready_go) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(id_fire && !id_ready_go));
    end
  end

  // The WB record is the end of the line; its load flag feeds nothing.
  logic unused_wb_ld;
  assign unused_wb_ld = slot_q[2].ld;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rsu;
    logic       rtu;
    logic [4:0] dest;
    logic       we;
    logic       ld;
    logic       idf;
    logic       exf;
    logic       memf;
    logic       wbr;
  } in_t;

  typedef struct {
    in_t        i;
    logic       rdy;
    logic [1:0] sel_rs;
    logic [1:0] sel_rt;
    int         cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  in_t  in_f = '0;   // stimulus for the forwarding instance
  in_t  in_n = '0;   // stimulus for the no-forwarding instance

  logic        rdy_f, rdy_n;
  logic [1:0]  rs_f, rt_f, rs_n, rt_n;
  logic [31:0] cnt_f, cnt_n;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.FORWARD_EN(1'b1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_valid(in_f.valid), .id_rs_addr(in_f.rs), .id_rt_addr(in_f.rt),
    .id_rs_used(in_f.rsu), .id_rt_used(in_f.rtu),
    .id_dest_addr(in_f.dest), .id_dest_we(in_f.we), .id_is_load(in_f.ld),
    .id_fire(in_f.idf), .exe_fire(in_f.exf), .mem_fire(in_f.memf), .wb_retire(in_f.wbr),
    .id_ready_go(rdy_f), .fwd_sel_rs(rs_f), .fwd_sel_rt(rt_f), .stall_cnt(cnt_f)
  );

  hazard_ctrl #(.FORWARD_EN(1'b0), .CNT_W(32)) dut_nf (
    .clk(clk), .reset(reset),
    .id_valid(in_n.valid), .id_rs_addr(in_n.rs), .id_rt_addr(in_n.rt),
    .id_rs_used(in_n.rsu), .id_rt_used(in_n.rtu),
    .id_dest_addr(in_n.dest), .id_dest_we(in_n.we), .id_is_load(in_n.ld),
    .id_fire(in_n.idf), .exe_fire(in_n.exf), .mem_fire(in_n.memf), .wb_retire(in_n.wbr),
    .id_ready_go(rdy_n), .fwd_sel_rs(rs_n), .fwd_sel_rt(rt_n), .stall_cnt(cnt_n)
  );

  function automatic in_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                             input logic rsu, input logic rtu, input logic [4:0] dest,
                             input logic we, input logic ld, input logic idf,
                             input logic exf, input logic memf, input logic wbr);
    in_t r;
    r = '{valid: v, rs: rs, rt: rt, rsu: rsu, rtu: rtu, dest: dest, we: we, ld: ld,
          idf: idf, exf: exf, memf: memf, wbr: wbr};
    return r;
  endfunction

  task automatic add(input in_t i, input logic rdy, input logic [1:0] srs,
                     input logic [1:0] srt, input int cnt);
    vec_t v;
    v.i = i; v.rdy = rdy; v.sel_rs = srs; v.sel_rt = srt; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   v  rs  rt  rsu rtu dest we ld idf exf memf wbr     rdy rs     rt     cnt
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),            1, 2'b00, 2'b00, 0); // idle after reset
    add(mk(1, 1, 2, 1, 1, 3, 1, 0, 1, 0, 0, 0),            1, 2'b00, 2'b00, 0); // issue addu $3
    add(mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0, 0),            1, 2'b01, 2'b00, 0); // addu $4,$3,$5
    add(mk(1, 3, 5, 1, 1, 4, 1, 0, 1, 1, 0, 0),            1, 2'b01, 2'b00, 0); // same, fires
    add(mk(1, 4, 3, 1, 1, 3, 1, 0, 1, 1, 1, 0),            1, 2'b01, 2'b10, 0); // EXE=$4 MEM=$3
    add(mk(1, 3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0),            1, 2'b01, 2'b10, 0); // $3 EXE+WB: EXE wins
    add(mk(0, 3, 4, 1, 1, 0, 0, 0, 0, 1, 1, 0),            1, 2'b00, 2'b00, 0); // no valid: RF
    add(mk(1, 4, 3, 1, 1, 0, 0, 0, 0, 0, 1, 1),            1, 2'b11, 2'b10, 0); // WB=$4 MEM=$3
    add(mk(1, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1),            1, 2'b11, 2'b00, 0); // WB=$3 only
    add(mk(1, 3, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0),            1, 2'b00, 2'b00, 0); // empty; issue we $0
    add(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0),            1, 2'b00, 2'b00, 0); // $0 never hazards
    add(mk(1, 0, 0, 1, 1, 3, 1, 1, 1, 1, 0, 0),            1, 2'b00, 2'b00, 0); // issue lw $3
    add(mk(1, 3, 3, 0, 1, 5, 1, 0, 0, 1, 1, 0),            0, 2'b00, 2'b01, 0); // load-use stall
    add(mk(1, 3, 3, 0, 1, 5, 1, 0, 1, 1, 1, 0),            1, 2'b00, 2'b10, 1); // lw in MEM: fwd
    add(mk(1, 5, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0),            1, 2'b01, 2'b11, 1); // lw in WB fwd
    add(mk(1, 5, 5, 0, 0, 6, 1, 1, 1, 1, 0, 0),            1, 2'b00, 2'b00, 1); // unused ops; issue lw $6
    add(mk(1, 6, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0),            0, 2'b01, 2'b10, 1); // lw $6 in EXE: stall
    add(mk(1, 6, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0),            0, 2'b01, 2'b10, 2); // still held
    add(mk(0, 6, 5, 1, 1, 0, 0, 0, 0, 1, 0, 0),            1, 2'b00, 2'b00, 3); // invalid: go

    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    foreach (vecs[k]) begin
      in_f = vecs[k].i;
      #1;
      chk($sformatf("v%0d ready_go", k), {31'd0, rdy_f}, {31'd0, vecs[k].rdy});
      chk($sformatf("v%0d fwd_rs", k), {30'd0, rs_f}, {30'd0, vecs[k].sel_rs});
      chk($sformatf("v%0d fwd_rt", k), {30'd0, rt_f}, {30'd0, vecs[k].sel_rt});
      chk($sformatf("v%0d stall_cnt", k), cnt_f, vecs[k].cnt);
      $display("vec %0d: rdy=%0b rs=%0b rt=%0b cnt=%0d", k, rdy_f, rs_f, rt_f, cnt_f);
      tick();
    end

    // No forwarding: dependent addu waits for EXE, MEM and WB to clear.
    in_n = mk(1, 1, 2, 1, 1, 3, 1, 0, 1, 0, 0, 0);
    tick();
    begin
      int stalls = 0;
      int cycles = 0;
      in_n = mk(1, 3, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      while (!rdy_n && cycles < 10) begin
        chk($sformatf("nf fwd_rs c%0d", cycles), {30'd0, rs_n}, 32'd0);
        stalls++;
        cycles++;
        // Advance the producer one stage per cycle.
        in_n.exf  = (cycles == 1);
        in_n.memf = (cycles == 2);
        in_n.wbr  = (cycles == 3);
        tick();
        in_n.exf = 1'b0; in_n.memf = 1'b0; in_n.wbr = 1'b0;
        #1;
      end
      chk("nf stall cycles", stalls, 32'd3);
      chk("nf ready_go", {31'd0, rdy_n}, 32'd1);
      chk("nf stall_cnt", cnt_n, 32'd3);
      $display("nf: stalls=%0d cnt=%0d rdy=%0b", stalls, cnt_n, rdy_n);
    end
    in_n = '0;

    // Fill all three slots with $9, then reset mid-flight.
    for (int c = 0; c < 3; c++) begin
      in_f = mk(1, 0, 0, 0, 0, 9, 1, 0, 1, 1, 1, 0);
      tick();
    end
    in_f = mk(1, 9, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pre-reset fwd_rs", {30'd0, rs_f}, 32'd1);
    in_n = mk(1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0);
    tick();
    in_n = mk(1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pre-reset nf ready_go", {31'd0, rdy_n}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("post-reset ready_go", {31'd0, rdy_f}, 32'd1);
    chk("post-reset fwd_rs", {30'd0, rs_f}, 32'd0);
    chk("post-reset fwd_rt", {30'd0, rt_f}, 32'd0);
    chk("post-reset stall_cnt", cnt_f, 32'd0);
    chk("post-reset nf ready_go", {31'd0, rdy_n}, 32'd1);
    chk("post-reset nf stall_cnt", cnt_n, 32'd0);
    $display("reset: rdy=%0b rs=%0b rt=%0b cnt=%0d nf_rdy=%0b", rdy_f, rs_f, rt_f, cnt_f, rdy_n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
